// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite slave mapping 32-bit word accesses onto a 16-bit asynchronous SRAM.
// Each word costs two halfword cycles (low half first), with a programmable strobe width.
module ahb_sram_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [1:0]  HTRANS,
  input  logic [14:0] HADDR,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [18:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_lb_n,
  output logic        sram_ub_n
);

  localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StSetup,
    StStrobe,
    StHold,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [14:0]       haddr_q, haddr_d;
  logic              wr_q, wr_d;
  logic              half_q, half_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       wbuf_q, wbuf_d;
  logic [31:0]       rbuf_q, rbuf_d;
  logic [31:0]       hrdata_q, hrdata_d;
  logic              accept;
  logic              in_cycle;
  logic              unused_htrans0;

  // HTRANS[0] only separates NONSEQ from SEQ, which this slave treats identically.
  assign unused_htrans0 = HTRANS[0];
  assign accept = HSEL & HREADY & HTRANS[1];

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= StIdle;
      haddr_q  <= '0;
      wr_q     <= 1'b0;
      half_q   <= 1'b0;
      cnt_q    <= '0;
      wbuf_q   <= '0;
      rbuf_q   <= '0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      wr_q     <= wr_d;
      half_q   <= half_d;
      cnt_q    <= cnt_d;
      wbuf_q   <= wbuf_d;
      rbuf_q   <= rbuf_d;
      hrdata_q <= hrdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    haddr_d  = haddr_q;
    wr_d     = wr_q;
    half_d   = half_q;
    cnt_d    = cnt_q;
    wbuf_d   = wbuf_q;
    rbuf_d   = rbuf_q;
    hrdata_d = hrdata_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          state_d = StStart;
          haddr_d = HADDR;
          wr_d    = HWRITE;
        end else begin
          state_d = StIdle;
        end
      end
      StStart: begin
        wbuf_d  = HWDATA;
        half_d  = 1'b0;
        state_d = StSetup;
      end
      StSetup: begin
        cnt_d   = CntW'(WAIT_CYCLES - 1);
        state_d = StStrobe;
      end
      StStrobe: begin
        if (cnt_q == '0) begin
          // Sample on the last strobe edge, while OE# is still asserted.
          if (!wr_q) begin
            if (half_q) rbuf_d[31:16] = sram_dq_in;
            else        rbuf_d[15:0]  = sram_dq_in;
          end
          state_d = StHold;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StHold: begin
        if (!half_q) begin
          half_d  = 1'b1;
          state_d = StSetup;
        end else begin
          state_d = StDone;
          if (!wr_q) hrdata_d = rbuf_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_cycle    = (state_q == StSetup) || (state_q == StStrobe) || (state_q == StHold);
    HREADYOUT   = (state_q == StIdle) || (state_q == StDone);
    HRDATA      = hrdata_q;
    HRESP       = 1'b0;
    sram_addr   = {3'b000, haddr_q, half_q};
    sram_dq_out = half_q ? wbuf_q[31:16] : wbuf_q[15:0];
    sram_dq_oe  = in_cycle & wr_q;
    sram_ce_n   = ~in_cycle;
    sram_lb_n   = ~in_cycle;
    sram_ub_n   = ~in_cycle;
    sram_we_n   = ~((state_q == StStrobe) & wr_q);
    sram_oe_n   = ~((state_q == StStrobe) & ~wr_q);
  end

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Bench for ahb_sram_ctrl: two instances (strobe width 1 and 3) against SRAM models and a
// word-level memory model of what each AHB read must return.
module tb_ahb_sram_ctrl;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        hsel1 = 1'b0, hsel3 = 1'b0;
  logic        HREADY = 1'b1;
  logic [1:0]  HTRANS = 2'b00;
  logic [14:0] HADDR = '0;
  logic        HWRITE = 1'b0;
  logic [31:0] HWDATA = '0;

  logic [31:0] hrdata1, hrdata3;
  logic        rdy1, rdy3, hresp1, hresp3;
  logic [18:0] addr1, addr3;
  logic [15:0] dqo1, dqo3, dqi1, dqi3;
  logic        dqoe1, dqoe3, ce1, ce3, oe1, oe3, we1, we3, lb1, lb3, ub1, ub3;

  always #5 HCLK = ~HCLK;

  ahb_sram_ctrl #(.WAIT_CYCLES(1)) u_dut1 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel1), .HREADY(HREADY), .HTRANS(HTRANS),
    .HADDR(HADDR), .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(hrdata1), .HREADYOUT(rdy1),
    .HRESP(hresp1), .sram_addr(addr1), .sram_dq_out(dqo1), .sram_dq_in(dqi1),
    .sram_dq_oe(dqoe1), .sram_ce_n(ce1), .sram_oe_n(oe1), .sram_we_n(we1),
    .sram_lb_n(lb1), .sram_ub_n(ub1)
  );

  ahb_sram_ctrl #(.WAIT_CYCLES(3)) u_dut3 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel3), .HREADY(HREADY), .HTRANS(HTRANS),
    .HADDR(HADDR), .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(hrdata3), .HREADYOUT(rdy3),
    .HRESP(hresp3), .sram_addr(addr3), .sram_dq_out(dqo3), .sram_dq_in(dqi3),
    .sram_dq_oe(dqoe3), .sram_ce_n(ce3), .sram_oe_n(oe3), .sram_we_n(we3),
    .sram_lb_n(lb3), .sram_ub_n(ub3)
  );

  // Asynchronous SRAM models: latch on the clock edge while WE# is low, read combinationally.
  logic [15:0] mem1 [65536];
  logic [15:0] mem3 [65536];
  assign dqi1 = mem1[addr1[15:0]];
  assign dqi3 = mem3[addr3[15:0]];
  always @(posedge HCLK) begin
    if (!ce1 && !we1 && !lb1 && !ub1) mem1[addr1[15:0]] <= dqo1;
    if (!ce3 && !we3 && !lb3 && !ub3) mem3[addr3[15:0]] <= dqo3;
  end

  // Activity counters sampled mid-cycle.
  int we_low1 = 0, oe_low1 = 0, dq_on1 = 0, ce_low1 = 0, nrdy1 = 0, both1 = 0;
  int we_low3 = 0, oe_low3 = 0, dq_on3 = 0, ce_low3 = 0, nrdy3 = 0, both3 = 0;
  always @(negedge HCLK) begin
    if (!we1) we_low1++;
    if (!oe1) oe_low1++;
    if (dqoe1) dq_on1++;
    if (!ce1) ce_low1++;
    if (!rdy1) nrdy1++;
    if (!we1 && !oe1) both1++;
    if (!we3) we_low3++;
    if (!oe3) oe_low3++;
    if (dqoe3) dq_on3++;
    if (!ce3) ce_low3++;
    if (!rdy3) nrdy3++;
    if (!we3 && !oe3) both3++;
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] model1 [int];
  logic [31:0] model3 [int];
  logic [31:0] last_rd1 = '0, last_rd3 = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge HCLK);
    #1;
  endtask

  function automatic logic rdy_of(input int sel);
    return (sel == 3) ? rdy3 : rdy1;
  endfunction

  task automatic addr_phase(input int sel, input bit wr, input logic [14:0] a);
    hsel1  = (sel == 1);
    hsel3  = (sel == 3);
    HTRANS = 2'b10;
    HADDR  = a;
    HWRITE = wr;
  endtask

  // Starts just before the accepting edge, returns in the DONE cycle.
  task automatic data_phase(input int sel, input logic [31:0] d, output logic [31:0] rd,
                            output int waits, output int we_n, output int oe_n, output int dq_n);
    int we0, oe0, dq0;
    tick();
    hsel1  = 1'b0;
    hsel3  = 1'b0;
    HTRANS = 2'b00;
    HWDATA = d;
    we0 = (sel == 3) ? we_low3 : we_low1;
    oe0 = (sel == 3) ? oe_low3 : oe_low1;
    dq0 = (sel == 3) ? dq_on3 : dq_on1;
    waits = 0;
    while (!rdy_of(sel) && waits < 100) begin
      waits++;
      tick();
    end
    rd   = (sel == 3) ? hrdata3 : hrdata1;
    we_n = ((sel == 3) ? we_low3 : we_low1) - we0;
    oe_n = ((sel == 3) ? oe_low3 : oe_low1) - oe0;
    dq_n = ((sel == 3) ? dq_on3 : dq_on1) - dq0;
  endtask

  task automatic chk_write(input int sel, input logic [14:0] a, input logic [31:0] d,
                           input logic [31:0] rd, input int waits, input int wn, input int on);
    int w;
    logic [15:0] lo, hi;
    w  = (sel == 3) ? 3 : 1;
    lo = (sel == 3) ? mem3[{a, 1'b0}] : mem1[{a, 1'b0}];
    hi = (sel == 3) ? mem3[{a, 1'b1}] : mem1[{a, 1'b1}];
    check("wr_waits", waits, 2 * (w + 2) + 1);
    check("wr_we_cycles", wn, 2 * w);
    check("wr_oe_cycles", on, 0);
    check("wr_sram_lo", {16'h0, lo}, {16'h0, d[15:0]});
    check("wr_sram_hi", {16'h0, hi}, {16'h0, d[31:16]});
    check("wr_hrdata_held", rd, (sel == 3) ? last_rd3 : last_rd1);
    if (sel == 3) model3[int'(a)] = d;
    else          model1[int'(a)] = d;
  endtask

  task automatic chk_read(input int sel, input logic [14:0] a, input logic [31:0] rd,
                          input int waits, input int wn, input int on, input int dqn);
    int w;
    logic [31:0] exp;
    w = (sel == 3) ? 3 : 1;
    if (sel == 3) exp = model3.exists(int'(a)) ? model3[int'(a)] : 32'h0;
    else          exp = model1.exists(int'(a)) ? model1[int'(a)] : 32'h0;
    check("rd_data", rd, exp);
    check("rd_waits", waits, 2 * (w + 2) + 1);
    check("rd_oe_cycles", on, 2 * w);
    check("rd_we_cycles", wn, 0);
    check("rd_dq_oe", dqn, 0);
    if (sel == 3) last_rd3 = rd;
    else          last_rd1 = rd;
  endtask

  task automatic do_write(input int sel, input logic [14:0] a, input logic [31:0] d);
    logic [31:0] rd;
    int waits, wn, on, dqn;
    addr_phase(sel, 1'b1, a);
    data_phase(sel, d, rd, waits, wn, on, dqn);
    chk_write(sel, a, d, rd, waits, wn, on);
  endtask

  task automatic do_read(input int sel, input logic [14:0] a);
    logic [31:0] rd;
    int waits, wn, on, dqn;
    addr_phase(sel, 1'b0, a);
    data_phase(sel, $urandom, rd, waits, wn, on, dqn);
    chk_read(sel, a, rd, waits, wn, on, dqn);
  endtask

  initial begin
    logic [31:0] rd;
    int waits, wn, on, dqn, n;
    int ce0, ce30, nr0, nr30, we0, oe0;
    logic [14:0] addrs [$];
    logic [14:0] a;
    logic [31:0] d;

    // Reset state
    repeat (3) tick();
    HRESET = 1'b0;
    tick();
    check("rst_hreadyout", rdy1, 1'b1);
    check("rst_hrdata", hrdata1, 32'h0);
    check("rst_strobes", {ce1, oe1, we1, lb1, ub1}, 5'b11111);
    check("rst_dq_oe", dqoe1, 1'b0);
    check("rst_sram_addr", addr1, 19'h0);
    check("rst_hresp", {hresp1, hresp3}, 2'b00);

    // Word write then read back at word address 4
    do_write(1, 15'h0004, 32'hDEADBEEF);
    check("t2_sram_0x8", mem1[16'h0008], 16'hBEEF);
    check("t2_sram_0x9", mem1[16'h0009], 16'hDEAD);
    do_read(1, 15'h0004);

    // Reset during the strobe of a write aborts it immediately
    addr_phase(1, 1'b1, 15'h0010);
    tick();
    hsel1 = 1'b0;
    HTRANS = 2'b00;
    HWDATA = 32'h11112222;
    n = 0;
    while (we1 && n < 20) begin
      n++;
      tick();
    end
    check("t1_reached_strobe", we1, 1'b0);
    HRESET = 1'b1;
    tick();
    check("t1_we_n", we1, 1'b1);
    check("t1_dq_oe", dqoe1, 1'b0);
    check("t1_hreadyout", rdy1, 1'b1);
    check("t1_ce_n", ce1, 1'b1);
    check("t1_hrdata", hrdata1, 32'h0);
    tick();
    HRESET = 1'b0;
    last_rd1 = '0;
    last_rd3 = '0;
    ce0 = ce_low1;
    repeat (5) tick();
    check("t1_no_retry", ce_low1 - ce0, 0);

    // Back-to-back: write accepted in the DONE cycle of a read
    do_write(1, 15'h0000, 32'hA5A55A5A);
    addr_phase(1, 1'b0, 15'h0000);
    data_phase(1, 32'h0, rd, waits, wn, on, dqn);
    chk_read(1, 15'h0000, rd, waits, wn, on, dqn);
    addr_phase(1, 1'b1, 15'h7FFF);
    data_phase(1, 32'h12345678, rd, waits, wn, on, dqn);
    chk_write(1, 15'h7FFF, 32'h12345678, rd, waits, wn, on);
    check("t4_sram_0xfffe", mem1[16'hFFFE], 16'h5678);
    check("t4_sram_0xffff", mem1[16'hFFFF], 16'h1234);

    // Unselected or IDLE/BUSY cycles produce no SRAM activity
    ce0 = ce_low1; ce30 = ce_low3; nr0 = nrdy1; nr30 = nrdy3;
    we0 = we_low1 + we_low3; oe0 = oe_low1 + oe_low3;
    tick();
    hsel1 = 1'b0; hsel3 = 1'b0; HTRANS = 2'b10; HWRITE = 1'b1;
    repeat (10) tick();
    hsel1 = 1'b1; hsel3 = 1'b1; HTRANS = 2'b00;
    repeat (10) tick();
    HTRANS = 2'b01;
    repeat (10) tick();
    hsel1 = 1'b0; hsel3 = 1'b0; HTRANS = 2'b00;
    check("t5_ce_n_1", ce_low1 - ce0, 0);
    check("t5_ce_n_3", ce_low3 - ce30, 0);
    check("t5_we_oe", (we_low1 + we_low3 - we0) + (oe_low1 + oe_low3 - oe0), 0);
    check("t5_hreadyout", (nrdy1 - nr0) + (nrdy3 - nr30), 0);

    // Wider strobe instance
    do_write(3, 15'h0123, 32'hCAFEF00D);
    do_read(3, 15'h0123);
    for (int i = 0; i < 3; i++) begin
      a = 15'($urandom_range(0, 32767));
      d = $urandom;
      do_write(3, a, d);
      do_read(3, a);
    end

    // Random traffic with reads of previously written words
    for (int i = 0; i < 10; i++) begin
      a = 15'($urandom_range(0, 32767));
      d = $urandom;
      do_write(1, a, d);
      addrs.push_back(a);
      do_read(1, addrs[$urandom_range(0, addrs.size() - 1)]);
    end

    check("never_we_oe_both_low", both1 + both3, 0);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
